// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a scanned active-low 7-segment bus,
// recovers each digit and publishes whole frames over valid/ready.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    frame_ready,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int SW = NUM_DIGITS + 7;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_t;

  logic [SW-1:0]                sync_q;
  logic [SW-1:0]                samp_q;
  logic [SW-1:0]                prev_q;
  logic [7:0]                   cnt_q;
  state_t                       state_q;
  logic [NUM_DIGITS-1:0][3:0]   shadow_q;
  logic [NUM_DIGITS-1:0]        seen_q;

  logic [NUM_DIGITS-1:0]        an_act;
  logic [6:0]                   seg_s;
  logic                         changed;
  logic                         onehot;
  logic                         stable;
  logic                         capture;
  logic                         complete;
  logic                         has_f;
  logic [3:0]                   dec_nib;

  function automatic logic [3:0] dec7(input logic [6:0] s);
    logic [3:0] r;
    case (s)
      7'h40:   r = 4'h0;
      7'h79:   r = 4'h1;
      7'h24:   r = 4'h2;
      7'h30:   r = 4'h3;
      7'h19:   r = 4'h4;
      7'h12:   r = 4'h5;
      7'h02:   r = 4'h6;
      7'h78:   r = 4'h7;
      7'h00:   r = 4'h8;
      7'h18:   r = 4'h9;
      7'h7E:   r = 4'hE;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  // Classify the synchronized sample and derive capture/complete strobes
  always_comb begin
    an_act   = ~samp_q[SW-1:7];
    seg_s    = samp_q[6:0];
    changed  = (samp_q != prev_q);
    onehot   = (an_act != '0) &&
               ((an_act & (an_act - 1'b1)) == '0);
    stable   = !changed &&
               (cnt_q == 8'(STABLE_CYCLES - 1));
    capture  = (state_q == SETTLE) && onehot && stable;
    complete = &seen_q;
    dec_nib  = dec7(seg_s);
    has_f    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shadow_q[i] == 4'hF) has_f = 1'b1;
    end
  end

  // Two-flop synchronizer, change history and saturating stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      samp_q <= '1;
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {an_in, seg_in};
      samp_q <= sync_q;
      prev_q <= samp_q;
      if (changed) begin
        cnt_q <= '0;
      end else if (cnt_q < 8'(STABLE_CYCLES)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Per-digit capture FSM, shadow frame and frame handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '1;
      seen_q      <= '0;
      frame_data  <= '1;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (onehot) state_q <= SETTLE;
        end
        SETTLE: begin
          if (!onehot) begin
            state_q <= IDLE;
          end else if (stable) begin
            state_q <= CAPTURED;
          end
        end
        CAPTURED: begin
          if (changed) state_q <= onehot ? SETTLE : IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_act[i]) shadow_q[i] <= dec_nib;
        end
      end

      seen_q <= (complete ? '0 : seen_q) |
                (capture ? an_act : '0);

      if (complete) begin
        frame_data  <= shadow_q;
        frame_err   <= has_f;
        frame_valid <= 1'b1;
        if (frame_valid && !frame_ready) overrun <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
